// File: rtl/segment_mem_wb_hs.sv
// segment_mem_wb_hs: MEM->WB pipeline segment with a main+skid buffer, flush, lane mask, result mux and bubble counter
module segment_mem_wb_hs #(
    parameter int N = 8,
    parameter int R = 6,
    parameter int A = 4,
    parameter int F = 2,
    parameter int C = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                FlushM,
    input  logic                ValidM,
    output logic                AcceptM,
    input  logic                RegWriteM,
    input  logic                MemtoRegM,
    input  logic                FlagsWriteM,
    input  logic [F-1:0]        ALUFlagsM,
    input  logic [F-1:0]        VSIFlagM,
    input  logic [A-1:0]        WA3M,
    input  logic [R-1:0]        LaneMaskM,
    input  logic [R-1:0][N-1:0] ReadDataM,
    input  logic [R-1:0][N-1:0] ALUOutputM,
    input  logic                ReadyW,
    output logic                ValidW,
    output logic                RegWriteW,
    output logic                MemtoRegW,
    output logic                FlagsWriteW,
    output logic [F-1:0]        ALUFlagsW,
    output logic [F-1:0]        VSIFlagW,
    output logic [A-1:0]        WA3W,
    output logic [R-1:0][N-1:0] ReadDataW,
    output logic [R-1:0][N-1:0] ALUOutputW,
    output logic [R-1:0]        LaneWriteW,
    output logic [R-1:0][N-1:0] ResultW,
    output logic [C-1:0]        BubbleCountW
);
    typedef struct packed {
        logic                reg_write;
        logic                mem_to_reg;
        logic                flags_write;
        logic [F-1:0]        alu_flags;
        logic [F-1:0]        vsi_flag;
        logic [A-1:0]        wa3;
        logic [R-1:0]        lane_mask;
        logic [R-1:0][N-1:0] read_data;
        logic [R-1:0][N-1:0] alu_output;
    } entry_t;

    entry_t       main_q, main_n, skid_q, skid_n, in_e;
    logic         main_v, main_v_n, skid_v, skid_v_n;
    logic         s, d;
    logic [C-1:0] bubble;

    assign in_e = '{reg_write: RegWriteM, mem_to_reg: MemtoRegM, flags_write: FlagsWriteM,
                    alu_flags: ALUFlagsM, vsi_flag: VSIFlagM, wa3: WA3M, lane_mask: LaneMaskM,
                    read_data: ReadDataM, alu_output: ALUOutputM};

    // AcceptM depends only on reset and the skid register, never on ReadyW
    assign AcceptM = reset & ~skid_v;
    assign s       = ValidM & AcceptM;
    assign d       = main_v & ReadyW;

    // next-state of the two-entry buffer, highest priority first
    always_comb begin
        main_n   = main_q;
        skid_n   = skid_q;
        main_v_n = main_v;
        skid_v_n = skid_v;
        if (FlushM) begin
            main_v_n = 1'b0;
            skid_v_n = 1'b0;
        end else if (skid_v) begin
            if (d) begin
                main_n   = skid_q;
                main_v_n = 1'b1;
                skid_v_n = 1'b0;
            end
        end else if (s) begin
            if (!main_v || d) begin
                main_n   = in_e;
                main_v_n = 1'b1;
            end else begin
                skid_n   = in_e;
                skid_v_n = 1'b1;
            end
        end else if (d) begin
            main_v_n = 1'b0;
        end
    end

    // buffer registers, captured on the falling edge
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            main_q <= '0;
            skid_q <= '0;
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else begin
            main_q <= main_n;
            skid_q <= skid_n;
            main_v <= main_v_n;
            skid_v <= skid_v_n;
        end
    end

    // bubble counter: WB ready with nothing to take, saturating, immune to flush
    always_ff @(negedge clk or negedge reset) begin
        if (!reset)
            bubble <= '0;
        else if (ReadyW && !main_v && bubble != {C{1'b1}})
            bubble <= bubble + C'(1);
    end

    assign ValidW       = main_v;
    assign RegWriteW    = main_q.reg_write & main_v;
    assign FlagsWriteW  = main_q.flags_write & main_v;
    assign MemtoRegW    = main_q.mem_to_reg;
    assign ALUFlagsW    = main_q.alu_flags;
    assign VSIFlagW     = main_q.vsi_flag;
    assign WA3W         = main_q.wa3;
    assign ReadDataW    = main_q.read_data;
    assign ALUOutputW   = main_q.alu_output;
    assign LaneWriteW   = {R{RegWriteW}} & main_q.lane_mask;
    assign BubbleCountW = bubble;

    for (genvar i = 0; i < R; i++) begin : g_lane
        assign ResultW[i] = MemtoRegW ? ReadDataW[i] : ALUOutputW[i];
    end
endmodule

// File: tb/tb_segment_mem_wb_hs.sv
// tb_segment_mem_wb_hs: scoreboard bench for the MEM->WB segment with directed vectors
module tb_segment_mem_wb_hs;
    localparam int N = 8, R = 6, A = 4, F = 2, C = 4;

    logic                clk = 1'b0;
    logic                reset, FlushM, ValidM, AcceptM, RegWriteM, MemtoRegM, FlagsWriteM, ReadyW;
    logic [F-1:0]        ALUFlagsM, VSIFlagM, ALUFlagsW, VSIFlagW;
    logic [A-1:0]        WA3M, WA3W;
    logic [R-1:0]        LaneMaskM, LaneWriteW;
    logic [R-1:0][N-1:0] ReadDataM, ALUOutputM, ReadDataW, ALUOutputW, ResultW;
    logic                ValidW, RegWriteW, MemtoRegW, FlagsWriteW;
    logic [C-1:0]        BubbleCountW;

    typedef struct {
        logic [A-1:0] wa;
        logic [47:0]  res;
        logic [5:0]   lw;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    segment_mem_wb_hs #(.N(N), .R(R), .A(A), .F(F), .C(C)) dut (
        .clk(clk), .reset(reset), .FlushM(FlushM), .ValidM(ValidM), .AcceptM(AcceptM),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .FlagsWriteM(FlagsWriteM),
        .ALUFlagsM(ALUFlagsM), .VSIFlagM(VSIFlagM), .WA3M(WA3M), .LaneMaskM(LaneMaskM),
        .ReadDataM(ReadDataM), .ALUOutputM(ALUOutputM), .ReadyW(ReadyW), .ValidW(ValidW),
        .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .FlagsWriteW(FlagsWriteW),
        .ALUFlagsW(ALUFlagsW), .VSIFlagW(VSIFlagW), .WA3W(WA3W), .ReadDataW(ReadDataW),
        .ALUOutputW(ALUOutputW), .LaneWriteW(LaneWriteW), .ResultW(ResultW),
        .BubbleCountW(BubbleCountW)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // inputs change 2 time units after the capturing falling edge
    task automatic drive(input logic v, input logic rdy, input logic fl, input logic [A-1:0] wa,
                         input logic mtr, input logic rw, input logic [R-1:0] lm,
                         input logic [7:0] rd, input logic [7:0] al,
                         input logic [47:0] er, input logic [5:0] elw);
        @(negedge clk);
        #2;
        ValidM = v; ReadyW = rdy; FlushM = fl; WA3M = wa; MemtoRegM = mtr; RegWriteM = rw;
        LaneMaskM = lm; ReadDataM = {6{rd}}; ALUOutputM = {6{al}};
        if (fl) sb.delete();
        else if (v && AcceptM) sb.push_back('{wa, er, elw});
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, rdy, 1'b0, '0, 1'b0, 1'b0, '0, 8'h00, 8'h00, '0, '0);
    endtask

    task automatic ent(input logic rdy, input logic [A-1:0] wa);
        drive(1'b1, rdy, 1'b0, wa, 1'b0, 1'b1, 6'h3F, 8'h00, 8'h00, 48'h0, 6'h3F);
    endtask

    // monitor: the rising edge is midway between captures, so outputs are stable here
    always @(posedge clk) begin
        if (ValidW && ReadyW) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", {60'h0, WA3W}, 64'hFFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wa3", WA3W, e.wa);
                chk("result", ResultW, e.res);
                chk("lane_write", LaneWriteW, e.lw);
            end
        end
    end

    initial begin
        reset = 1'b0; ValidM = 1'b1; ReadyW = 1'b0; FlushM = 1'b0; RegWriteM = 1'b1;
        MemtoRegM = 1'b1; FlagsWriteM = 1'b1; ALUFlagsM = 2'b11; VSIFlagM = 2'b10;
        WA3M = 4'h3; LaneMaskM = 6'h3F; ReadDataM = {6{8'h77}}; ALUOutputM = {6{8'h66}};
        // reset with a valid entry presented
        repeat (2) @(negedge clk);
        #2;
        chk("rst_validw", ValidW, 0);
        chk("rst_acceptm", AcceptM, 0);
        chk("rst_result", ResultW, 0);
        chk("rst_wa3", WA3W, 0);
        chk("rst_bubble", BubbleCountW, 0);
        chk("rst_flags", {RegWriteW, FlagsWriteW, ALUFlagsW, VSIFlagW}, 0);
        ValidM = 1'b0;
        reset = 1'b1;
        #1;
        chk("release_acceptm", AcceptM, 1);
        // back-to-back stream
        ent(1'b0, 4'd1);
        ent(1'b1, 4'd2);
        chk("stream_accept2", AcceptM, 1);
        ent(1'b1, 4'd3);
        chk("stream_accept3", AcceptM, 1);
        ent(1'b1, 4'd4);
        chk("stream_accept4", AcceptM, 1);
        idle(1'b1);
        chk("stream_bubble_a", BubbleCountW, 0);
        idle(1'b0);
        chk("stream_bubble_b", BubbleCountW, 0);
        chk("stream_drained", ValidW, 0);
        // backpressure fills the skid
        ent(1'b0, 4'd5);
        ent(1'b0, 4'd6);
        chk("bp_accept_main", AcceptM, 1);
        idle(1'b0);
        chk("bp_accept_full", AcceptM, 0);
        chk("bp_main_wa", WA3W, 5);
        idle(1'b1);
        chk("bp_still_full", AcceptM, 0);
        idle(1'b1);
        chk("bp_accept_back", AcceptM, 1);
        chk("bp_main_is_b", WA3W, 6);
        idle(1'b0);
        // flush with the skid full and a valid entry incoming
        ent(1'b0, 4'd7);
        ent(1'b0, 4'd8);
        idle(1'b0);
        chk("pre_flush_accept", AcceptM, 0);
        drive(1'b1, 1'b0, 1'b1, 4'd9, 1'b0, 1'b1, 6'h3F, 8'h00, 8'h00, '0, '0);
        idle(1'b0);
        chk("flush_validw", ValidW, 0);
        chk("flush_acceptm", AcceptM, 1);
        chk("flush_regwrite", RegWriteW, 0);
        // result mux and lane mask
        drive(1'b1, 1'b1, 1'b0, 4'd10, 1'b1, 1'b1, 6'b000101, 8'hA5, 8'h3C, {6{8'hA5}}, 6'b000101);
        drive(1'b1, 1'b1, 1'b0, 4'd11, 1'b0, 1'b1, 6'b000101, 8'hA5, 8'h3C, {6{8'h3C}}, 6'b000101);
        drive(1'b1, 1'b1, 1'b0, 4'd12, 1'b0, 1'b0, 6'b111111, 8'hA5, 8'h3C, {6{8'h3C}}, 6'b000000);
        // bubble saturation
        repeat (20) idle(1'b1);
        chk("bubble_sat", BubbleCountW, 4'hF);
        idle(1'b0);
        // reset asserted while an entry is held
        ent(1'b0, 4'd13);
        idle(1'b0);
        chk("pre_reset_valid", ValidW, 1);
        reset = 1'b0;
        sb.delete();
        #1;
        chk("async_rst_validw", ValidW, 0);
        chk("async_rst_bubble", BubbleCountW, 0);
        chk("async_rst_acceptm", AcceptM, 0);
        #1;
        reset = 1'b1;
        repeat (3) idle(1'b1);
        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
